// File: rtl/photon_binner_pkg.sv
// Shared correlator package: default count width, binner state encoding and
// the saturating-add helper used by the photon binner.
package photon_binner_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  // Returns min(a + b, max) without wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/bin_out_reg.sv
// Single-entry valid/ready holding register for completed bins; drops a new
// result when the register is still occupied and counts the drops.
module bin_out_reg #(
  parameter int unsigned DW     = 8,
  parameter int unsigned LOST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic [DW-1:0]     dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [LOST_W-1:0] lost_bins
);

  logic [DW-1:0]     data_q, data_d;
  logic              valid_q, valid_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              xfer;

  assign xfer = valid_q & dout_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    lost_d  = lost_q;
    if (clr) begin
      data_d  = '0;
      valid_d = 1'b0;
      lost_d  = '0;
    end else if (in_valid) begin
      if (!valid_q || xfer) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else if (lost_q != '1) begin
        lost_d = lost_q + LOST_W'(1);
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      lost_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;
  assign lost_bins  = lost_q;

endmodule

// File: rtl/photon_binner.sv
// Photon binner: accumulates gated photon events over bin_len-cycle bins and
// offers one saturating count per bin to the correlator.
module photon_binner
  import photon_binner_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned LOST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr,
  input  logic [DIV_W-1:0]  bin_len,
  input  logic              sin,
  output logic [CNT_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              sat,
  output logic [LOST_W-1:0] lost_bins
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             state_q, state_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [DIV_W-1:0] len_m1;
  logic [CNT_W-1:0] sum;
  logic             ovf;
  logic             res_valid;

  // bin_len of 0 behaves as a 1-cycle bin.
  assign len_m1 = (bin_len == '0) ? '0 : bin_len - DIV_W'(1);
  assign sum    = CNT_W'(sat_add(32'(acc_q), 32'(sin), 32'(CNT_MAX)));
  assign ovf    = (acc_q == CNT_MAX) && sin;

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    res_valid = 1'b0;
    if (clr) begin
      acc_d   = '0;
      tick_d  = len_m1;
      sat_d   = 1'b0;
      state_d = run ? ST_COUNT : ST_IDLE;
    end else if (state_q == ST_IDLE) begin
      acc_d = '0;
      if (run) begin
        state_d = ST_COUNT;
        tick_d  = len_m1;
      end
    end else if (tick_q == '0) begin
      // Terminal cycle completes the bin even if run drops now.
      res_valid = 1'b1;
      if (ovf) sat_d = 1'b1;
      acc_d  = '0;
      tick_d = len_m1;
      if (!run) state_d = ST_IDLE;
    end else if (!run) begin
      acc_d   = '0;
      state_d = ST_IDLE;
    end else begin
      acc_d  = sum;
      tick_d = tick_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign sat = sat_q;

  bin_out_reg #(
    .DW     (CNT_W),
    .LOST_W (LOST_W)
  ) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .in_valid   (res_valid),
    .in_data    (sum),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .lost_bins  (lost_bins)
  );

endmodule
